// File: rtl/skew_feeder_pkg.sv
// Shared types and constants for the skew feeder: FSM states, array size, step count and
// element address layout {row, col}.
package skew_feeder_pkg;

  typedef enum logic {StIdle, StFeed} state_e;

  localparam int unsigned N_DIM    = 4;
  localparam int unsigned STEPS    = 2 * N_DIM - 1;
  localparam int unsigned ROW_W    = 2;
  localparam int unsigned COL_W    = 2;
  localparam int unsigned ADDR_W   = ROW_W + COL_W;
  localparam int unsigned NUM_ELEM = N_DIM * N_DIM;
  localparam int unsigned T_W      = 3;

  localparam logic [T_W-1:0] T_LAST = T_W'(STEPS - 1);

endpackage

// File: rtl/skew_lane.sv
// Skew lane: maps the current feed step to the element index this lane presents, or flags the
// lane idle (index 0) when the step lies outside its diagonal window.
module skew_lane
  import skew_feeder_pkg::*;
#(
  parameter int unsigned LANE  = 0,
  parameter bit          NORTH = 1'b0
) (
  input  logic [T_W-1:0]    i_t,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_idx
);

  localparam logic [ROW_W-1:0] LANE_IDX = ROW_W'(LANE);

  logic [T_W:0]     w_diff;
  logic [COL_W-1:0] w_pos;

  always_comb begin
    w_diff  = {1'b0, i_t} - (T_W + 1)'(LANE);
    // Borrow means t < lane; bit 2 set means t - lane > 3.
    o_valid = ~w_diff[T_W] & ~w_diff[T_W-1];
    w_pos   = ~w_diff[COL_W-1:0];
    o_idx   = '0;
    if (o_valid) begin
      o_idx = NORTH ? {w_pos, LANE_IDX} : {LANE_IDX, w_pos};
    end
  end

endmodule

// File: rtl/skew_feeder.sv
// Skew feeder: stores 4x4 A/B matrices and streams them diagonally skewed into a systolic array.
// Define SKEW_FEEDER_DBUF_EN for double-buffered storage with back-to-back feeds.
module skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic              i_wr_sel,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_feed_done,
  output logic [DATA_W-1:0] o_inp_west0,
  output logic [DATA_W-1:0] o_inp_west1,
  output logic [DATA_W-1:0] o_inp_west2,
  output logic [DATA_W-1:0] o_inp_west3,
  output logic [DATA_W-1:0] o_inp_north0,
  output logic [DATA_W-1:0] o_inp_north1,
  output logic [DATA_W-1:0] o_inp_north2,
  output logic [DATA_W-1:0] o_inp_north3
);

  if (N != N_DIM) begin : g_bad_n
    $error("skew_feeder: N must be 4");
  end

  state_e           r_state, w_state_d;
  logic [T_W-1:0]   r_t, w_t_d;
  logic             w_restart, w_wr_fire, w_wr_bank0;
  logic [DATA_W-1:0] r_a0 [NUM_ELEM];
  logic [DATA_W-1:0] r_b0 [NUM_ELEM];

  logic              w_west_v [N_DIM];
  logic              w_north_v [N_DIM];
  logic [ADDR_W-1:0] w_west_idx [N_DIM];
  logic [ADDR_W-1:0] w_north_idx [N_DIM];
  logic [DATA_W-1:0] w_a_rd [N_DIM];
  logic [DATA_W-1:0] w_b_rd [N_DIM];
  logic [DATA_W-1:0] w_west_d [N_DIM];
  logic [DATA_W-1:0] w_north_d [N_DIM];
  logic [DATA_W-1:0] r_west [N_DIM];
  logic [DATA_W-1:0] r_north [N_DIM];
  logic              w_done_d, r_feed_done;

`ifdef SKEW_FEEDER_DBUF_EN
  logic              r_pending, w_pending_d, r_bank, w_wr_bank1;
  logic [DATA_W-1:0] r_a1 [NUM_ELEM];
  logic [DATA_W-1:0] r_b1 [NUM_ELEM];

  assign o_wr_ready = 1'b1;
  assign o_busy     = (r_state == StFeed) | r_pending;
  // In IDLE both banks take the write so contents persist across bank swaps.
  assign w_wr_bank0 = (r_state == StIdle) | r_bank;
  assign w_wr_bank1 = (r_state == StIdle) | ~r_bank;
`else
  assign o_wr_ready = (r_state == StIdle);
  assign o_busy     = (r_state == StFeed);
  assign w_wr_bank0 = 1'b1;
`endif

  assign w_wr_fire = i_wr_valid & o_wr_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_t     <= '0;
    end else begin
      r_state <= w_state_d;
      r_t     <= w_t_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_t_d     = r_t;
`ifdef SKEW_FEEDER_DBUF_EN
    w_pending_d = r_pending;
    w_restart   = (r_state == StFeed) && (r_t == T_LAST) && (r_pending || i_start);
    if (r_state == StFeed) begin
      if (r_t == T_LAST) begin
        w_pending_d = 1'b0;
      end else if (i_start) begin
        w_pending_d = 1'b1;
      end
    end
`else
    w_restart = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d = StFeed;
          w_t_d     = '0;
        end
      end
      StFeed: begin
        if (r_t == T_LAST) begin
          w_t_d = '0;
          if (!w_restart) w_state_d = StIdle;
        end else begin
          w_t_d = r_t + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

`ifdef SKEW_FEEDER_DBUF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= 1'b0;
      r_bank    <= 1'b0;
      for (int k = 0; k < NUM_ELEM; k++) begin
        r_a1[k] <= '0;
        r_b1[k] <= '0;
      end
    end else begin
      r_pending <= w_pending_d;
      if (w_restart) r_bank <= ~r_bank;
      if (w_wr_fire && w_wr_bank1) begin
        if (i_wr_sel) r_b1[i_wr_addr] <= i_wr_data;
        else          r_a1[i_wr_addr] <= i_wr_data;
      end
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_ELEM; k++) begin
        r_a0[k] <= '0;
        r_b0[k] <= '0;
      end
    end else if (w_wr_fire && w_wr_bank0) begin
      if (i_wr_sel) r_b0[i_wr_addr] <= i_wr_data;
      else          r_a0[i_wr_addr] <= i_wr_data;
    end
  end

  for (genvar g = 0; g < N_DIM; g++) begin : g_lane
    skew_lane #(.LANE(g), .NORTH(1'b0)) u_west (
      .i_t    (r_t),
      .o_valid(w_west_v[g]),
      .o_idx  (w_west_idx[g])
    );
    skew_lane #(.LANE(g), .NORTH(1'b1)) u_north (
      .i_t    (r_t),
      .o_valid(w_north_v[g]),
      .o_idx  (w_north_idx[g])
    );
  end

  always_comb begin
    for (int i = 0; i < N_DIM; i++) begin
`ifdef SKEW_FEEDER_DBUF_EN
      w_a_rd[i] = r_bank ? r_a1[w_west_idx[i]] : r_a0[w_west_idx[i]];
      w_b_rd[i] = r_bank ? r_b1[w_north_idx[i]] : r_b0[w_north_idx[i]];
`else
      w_a_rd[i] = r_a0[w_west_idx[i]];
      w_b_rd[i] = r_b0[w_north_idx[i]];
`endif
      w_west_d[i]  = '0;
      w_north_d[i] = '0;
      if (r_state == StFeed) begin
        if (w_west_v[i])  w_west_d[i]  = w_a_rd[i];
        if (w_north_v[i]) w_north_d[i] = w_b_rd[i];
      end
    end
    w_done_d = (r_state == StFeed) && (r_t == T_LAST);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_feed_done <= 1'b0;
      for (int i = 0; i < N_DIM; i++) begin
        r_west[i]  <= '0;
        r_north[i] <= '0;
      end
    end else begin
      r_feed_done <= w_done_d;
      for (int i = 0; i < N_DIM; i++) begin
        r_west[i]  <= w_west_d[i];
        r_north[i] <= w_north_d[i];
      end
    end
  end

  assign o_feed_done  = r_feed_done;
  assign o_inp_west0  = r_west[0];
  assign o_inp_west1  = r_west[1];
  assign o_inp_west2  = r_west[2];
  assign o_inp_west3  = r_west[3];
  assign o_inp_north0 = r_north[0];
  assign o_inp_north1 = r_north[1];
  assign o_inp_north2 = r_north[2];
  assign o_inp_north3 = r_north[3];

endmodule
